// File: rtl/truth_table_sweeper.sv
// Walks every input combination of a small combinational block in ascending order,
// captures its output after a settle interval and grades the table against a golden mask.
module truth_table_sweeper #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_y,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic [N_IN:0]        mismatch_cnt,
    output logic                 first_fail_valid,
    output logic [N_IN-1:0]      first_fail_idx,
    output logic                 pass
);

    localparam int W  = 2**N_IN;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0] dut_in_q, dut_in_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    table_q, table_d;
    logic [N_IN:0]   mismatch_q, mismatch_d;
    logic            ffv_q, ffv_d;
    logic [N_IN-1:0] ffi_q, ffi_d;
    logic            pass_q, pass_d;

    logic            miss;
    logic [N_IN:0]   mismatch_next;
    logic            last_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            dut_in_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            table_q    <= '0;
            mismatch_q <= '0;
            ffv_q      <= 1'b0;
            ffi_q      <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            dut_in_q   <= dut_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            table_q    <= table_d;
            mismatch_q <= mismatch_d;
            ffv_q      <= ffv_d;
            ffi_q      <= ffi_d;
            pass_q     <= pass_d;
        end
    end

    // Sample edge folds the current bit into the count so pass sees the final total.
    always_comb begin
        miss          = (dut_y != expected[idx_q]);
        mismatch_next = mismatch_q + (N_IN+1)'(miss);
        last_idx      = (idx_q == N_IN'(W-1));
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        dut_in_d   = dut_in_q;
        busy_d     = busy_q;
        done_d     = done_q;
        table_d    = table_q;
        mismatch_d = mismatch_q;
        ffv_d      = ffv_q;
        ffi_d      = ffi_q;
        pass_d     = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = DRIVE;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    idx_d      = '0;
                    cnt_d      = '0;
                    dut_in_d   = '0;
                    table_d    = '0;
                    mismatch_d = '0;
                    ffv_d      = 1'b0;
                    ffi_d      = '0;
                    pass_d     = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt_q != CW'(SETTLE_CYCLES-1)) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    table_d[idx_q] = dut_y;
                    mismatch_d     = mismatch_next;
                    if (miss && !ffv_q) begin
                        ffv_d = 1'b1;
                        ffi_d = idx_q;
                    end
                    if (last_idx) begin
                        state_d  = DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        dut_in_d = '0;
                        pass_d   = (mismatch_next == '0);
                    end else begin
                        idx_d    = idx_q + N_IN'(1);
                        dut_in_d = dut_in_q + N_IN'(1);
                        cnt_d    = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dut_in           = dut_in_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign table_out        = table_q;
    assign mismatch_cnt     = mismatch_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_idx   = ffi_q;
    assign pass             = pass_q;

endmodule
